counter_cmd_encoder: RTL and testbench
======================================

# counter_cmd_encoder

Upstream command stage for the 2-bit up/down Moore counter. It takes two raw, asynchronous push-button inputs (count-up, count-down), synchronises and debounces each one, and turns every debounced press into a single-cycle `enable` command in the counter's encoding: 01 up, 10 down, 00 hold. An optional auto-repeat mode emits further commands while a button stays held.

## Interface
- `DB_CYCLES`, 4: consecutive synchronised samples required to accept a level change (≥2).
- `HOLD_CYCLES`, 16: cycles from the initial press pulse to the first repeat pulse (≥2; used only with auto-repeat).
- `REPEAT_CYCLES`, 8: cycles between successive repeat pulses (≥2; used only with auto-repeat).
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `btn_up`  input  1  raw count-up button, asynchronous, active-high.
- `btn_down`  input  1  raw count-down button, asynchronous, active-high.
- `enable`  output  2  registered command to the counter: 01 up, 10 down, 00 hold. Never drives 11.
- `btn_state`  output  2  registered debounced levels, {down, up}.

## Operation
- Reset (`reset`=0, asynchronous): all synchroniser flops, debounced levels, counters and FSMs clear. `enable`=00 and `btn_state`=00 immediately.
- Synchroniser: each button has a 2-flop chain, `sN1`→`sN2`.
- Debouncer, per button, with a counter sized for `DB_CYCLES`:
  - If `sN2` equals the debounced level, the counter clears.
  - Otherwise the counter increments.
  - When `sN2` has differed on `DB_CYCLES` consecutive edges, the debounced level takes `sN2` and the counter clears.
  - A glitch shorter than `DB_CYCLES` samples is ignored.
- Per-button FSM, states IDLE, HELD, REPEAT:
  - IDLE→HELD on a debounced rising edge; this raises the button's press pulse.
  - HELD→REPEAT when the hold counter reaches `HOLD_CYCLES`; this raises a press pulse and reloads the counter. Auto-repeat builds only.
  - REPEAT→REPEAT each time the counter reaches `REPEAT_CYCLES`; this raises a press pulse.
  - HELD or REPEAT→IDLE on a debounced falling edge. No pulse is raised, and the counters clear.
- Command encode, registered:
  - Up pulse only → 01.
  - Down pulse only → 10.
  - Both pulses, or neither → 00.
  - Coincident pulses cancel. Neither is queued or replayed later.
- `enable` is non-zero for exactly one cycle per pulse. The downstream counter therefore steps exactly once per accepted event.

## Timing
- Press latency: `btn_up` high and stable before edge k → `enable`=01 in the cycle after edge k+1+`DB_CYCLES`. That edge is k+5 at the default `DB_CYCLES`=4.
- `btn_state` bit rises on the same edge as the first pulse.
- Release latency: the `btn_state` bit falls on edge m+1+`DB_CYCLES`, where m is the first edge sampling the low input.
- Auto-repeat: with the first pulse on edge E, further pulses occur on edges E+`HOLD_CYCLES`, E+`HOLD_CYCLES`+`REPEAT_CYCLES`, E+`HOLD_CYCLES`+2·`REPEAT_CYCLES`, and so on.
- Release before E+`HOLD_CYCLES` → no repeat pulse.
- The up and down paths are fully independent apart from the final encode.
- Reset mid-operation: output is 00 in the same cycle.
  - A button still held when `reset` deasserts is treated as a fresh press.
  - One pulse follows, `DB_CYCLES`+2 edges after release from reset.

## Configuration
- `COUNTER_CMD_AUTOREPEAT_EN` defined: the REPEAT state, hold counter and repeat counter are compiled in, with behaviour as above.
- Not defined: the FSM is IDLE/HELD only and there is no hold or repeat counter logic.
  - One pulse per press regardless of hold time.
  - `HOLD_CYCLES` and `REPEAT_CYCLES` are ignored.

## Test plan
- Reset: `reset`=0 asynchronously, mid-cycle, while `btn_up` is held → `enable`=00 and `btn_state`=00 at once. After deassert, exactly one 01 pulse follows 6 edges later (`DB_CYCLES`=4).
- Single press: `btn_up` high for 30 cycles, then low.
  - Without the macro: exactly one `enable`=01 cycle, at edge k+5.
  - `btn_state[0]` high from edge k+5 until 5 edges after release.
- Bounce: `btn_down` toggles with high runs of 1, 3, 2 cycles, then holds high.
  - No pulse during the bounce.
  - One `enable`=10 cycle 5 edges after the final rise reaches the synchroniser input, i.e. at k+5 with k the final rise.
- Simultaneous: `btn_up` and `btn_down` rise on the same cycle → `enable` stays 00 throughout, and `btn_state`=11.
- Auto-repeat (macro defined, defaults): `btn_up` held for 50 cycles.
  - 01 pulses on edges E, E+16, E+24, E+32, E+40, E+48.
  - None after release.
- Short hold with repeat enabled: `btn_up` held 12 cycles → exactly one 01 pulse, no repeat.

Source files
------------

// File: rtl/counter_cmd_encoder.sv
// Push-button command stage: sync, debounce and pulse-encode up/down buttons.
// Define COUNTER_CMD_AUTOREPEAT_EN to compile in hold-to-repeat.
module counter_cmd_encoder #(
    parameter int DB_CYCLES     = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] enable,
    output logic [1:0] btn_state
);

    localparam int DBW  = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
`ifdef COUNTER_CMD_AUTOREPEAT_EN
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = (HMAX > 2) ? $clog2(HMAX) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } state_e;
`else
    typedef enum logic {
        IDLE,
        HELD
    } state_e;
`endif

    if (DB_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("counter_cmd_encoder: cycle parameters must be >= 2");
    end

    logic [1:0] raw;
    logic [1:0] pulse;
    logic [1:0] level;
    logic [1:0] enable_q, enable_d;

    assign raw = {btn_down, btn_up};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic           s1_q, s2_q;
        logic           lvl_q, lvl_d;
        logic [DBW-1:0] db_q, db_d;
        logic           rise, fall;
        logic           pls;
        state_e         st_q, st_d;
`ifdef COUNTER_CMD_AUTOREPEAT_EN
        logic [HW-1:0]  hc_q, hc_d;
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                lvl_q <= 1'b0;
                db_q  <= '0;
                st_q  <= IDLE;
`ifdef COUNTER_CMD_AUTOREPEAT_EN
                hc_q  <= '0;
`endif
            end else begin
                s1_q  <= raw[b];
                s2_q  <= s1_q;
                lvl_q <= lvl_d;
                db_q  <= db_d;
                st_q  <= st_d;
`ifdef COUNTER_CMD_AUTOREPEAT_EN
                hc_q  <= hc_d;
`endif
            end
        end

        // Level flips on the DB_CYCLES-th consecutive differing sample.
        always_comb begin
            lvl_d = lvl_q;
            db_d  = '0;
            rise  = 1'b0;
            fall  = 1'b0;
            if (s2_q != lvl_q) begin
                if (db_q == DBW'(DB_CYCLES - 1)) begin
                    lvl_d = s2_q;
                    rise  = s2_q;
                    fall  = ~s2_q;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
        end

        always_comb begin
            st_d = st_q;
            pls  = 1'b0;
`ifdef COUNTER_CMD_AUTOREPEAT_EN
            hc_d = hc_q;
`endif
            unique case (st_q)
                IDLE: begin
                    if (rise) begin
                        st_d = HELD;
                        pls  = 1'b1;
                    end
                end
                HELD: begin
                    if (fall) begin
                        st_d = IDLE;
                    end
`ifdef COUNTER_CMD_AUTOREPEAT_EN
                    else if (hc_q == HW'(HOLD_CYCLES - 1)) begin
                        st_d = REPEAT;
                        pls  = 1'b1;
                    end
`endif
                end
`ifdef COUNTER_CMD_AUTOREPEAT_EN
                REPEAT: begin
                    if (fall) begin
                        st_d = IDLE;
                    end else if (hc_q == HW'(REPEAT_CYCLES - 1)) begin
                        pls = 1'b1;
                    end
                end
`endif
                default: st_d = IDLE;
            endcase
`ifdef COUNTER_CMD_AUTOREPEAT_EN
            // Any transition or pulse restarts the interval count.
            if (st_d != st_q || pls) begin
                hc_d = '0;
            end else if (st_q != IDLE) begin
                hc_d = hc_q + 1'b1;
            end
`endif
        end

        assign pulse[b] = pls;
        assign level[b] = lvl_q;
    end

    // Coincident pulses cancel rather than being queued.
    always_comb begin
        enable_d = 2'b00;
        unique case (1'b1)
            (pulse[0] & ~pulse[1]): enable_d = 2'b01;
            (pulse[1] & ~pulse[0]): enable_d = 2'b10;
            default:                enable_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q <= 2'b00;
        end else begin
            enable_q <= enable_d;
        end
    end

    assign enable    = enable_q;
    assign btn_state = level;

endmodule

// File: tb/tb_counter_cmd_encoder.sv
// Bench for counter_cmd_encoder: directed scenarios plus random presses
// against an edge-indexed behavioural model.
module tb_counter_cmd_encoder;

    localparam int DB   = 4;
    localparam int HOLD = 16;
    localparam int REP  = 8;
    localparam int HN   = 8192;

    logic       clk;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic [1:0] enable;
    logic [1:0] btn_state;

    int checks;
    int errors;
    int ecnt;

    counter_cmd_encoder #(
        .DB_CYCLES    (DB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .enable   (enable),
        .btn_state(btn_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

`ifdef COUNTER_CMD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    // Reference model: samples[n] is the raw input seen at edge n after reset.
    logic [1:0] samples [0:HN-1];
    int         m_n;
    int         m_run   [2];
    int         m_first [2];
    logic [1:0] m_lvl;
    logic [1:0] m_en;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_n        <= 0;
            m_run[0]   <= 0;
            m_run[1]   <= 0;
            m_first[0] <= 0;
            m_first[1] <= 0;
            m_lvl      <= 2'b00;
            m_en       <= 2'b00;
        end else begin
            automatic int         n   = m_n + 1;
            automatic logic [1:0] lv  = m_lvl;
            automatic logic [1:0] pl  = 2'b00;
            automatic int         run [2];
            automatic int         fst [2];
            samples[n % HN] = {btn_down, btn_up};
            for (int b = 0; b < 2; b++) begin
                automatic logic synced;
                synced = (n >= 3) ? samples[(n - 2) % HN][b] : 1'b0;
                run[b] = m_run[b];
                fst[b] = m_first[b];
                if (synced != lv[b]) run[b]++;
                else run[b] = 0;
                if (run[b] == DB) begin
                    lv[b]  = synced;
                    run[b] = 0;
                    if (synced) begin
                        pl[b]  = 1'b1;
                        fst[b] = n;
                    end
                end
                if (AR && lv[b] && !pl[b] && (n - fst[b]) >= HOLD &&
                    ((n - fst[b] - HOLD) % REP) == 0)
                    pl[b] = 1'b1;
            end
            m_n        <= n;
            m_run[0]   <= run[0];
            m_run[1]   <= run[1];
            m_first[0] <= fst[0];
            m_first[1] <= fst[1];
            m_lvl      <= lv;
            m_en       <= (pl == 2'b01) ? 2'b01 : (pl == 2'b10) ? 2'b10 : 2'b00;
        end
    end

    function automatic int exp_pulses(input int len);
        if (AR && len - 1 >= HOLD) return 2 + (len - 1 - HOLD) / REP;
        return 1;
    endfunction

    task automatic test_reset();
        int hits;
        int hit_edge;
        int rel;
        bit found;
        reset    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (enable !== 2'b00) begin
            errors++;
            $display("FAIL reset_enable: got %b want 00", enable);
        end
        checks++;
        if (btn_state !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: got %b want 00", btn_state);
        end
        reset  = 1'b1;
        btn_up = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (enable === 2'b01) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_prepulse: got no 01 within 20 cycles want 01");
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (enable !== 2'b00 || btn_state !== 2'b00) begin
            errors++;
            $display("FAIL reset_async: got en=%b st=%b want 00/00", enable, btn_state);
        end
        @(negedge clk);
        reset    = 1'b1;
        rel      = ecnt;
        hits     = 0;
        hit_edge = -1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (enable === 2'b01) begin
                hits++;
                hit_edge = ecnt;
            end
            checks++;
            if (enable !== m_en) begin
                errors++;
                $display("FAIL reset_model: got %b want %b", enable, m_en);
            end
        end
        checks++;
        if (hits != 1 || hit_edge != rel + DB + 2) begin
            errors++;
            $display("FAIL reset_repress: got %0d pulses at +%0d want 1 at +%0d",
                     hits, hit_edge - rel, DB + 2);
        end
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_hold(input int len);
        int   k;
        int   m;
        int   pe[$];
        int   rise_e;
        int   fall_e;
        logic prev;
        rise_e = -1;
        fall_e = -1;
        prev   = btn_state[0];
        k      = ecnt + 1;
        btn_up = 1'b1;
        for (int i = 0; i < len + 20; i++) begin
            if (i == len) btn_up = 1'b0;
            @(negedge clk);
            if (enable === 2'b01) pe.push_back(ecnt);
            if (!prev && btn_state[0] === 1'b1) rise_e = ecnt;
            if (prev && btn_state[0] === 1'b0) fall_e = ecnt;
            prev = btn_state[0];
            checks++;
            if (enable !== m_en || btn_state !== m_lvl) begin
                errors++;
                $display("FAIL hold%0d_model: got %b/%b want %b/%b",
                         len, enable, btn_state, m_en, m_lvl);
            end
        end
        m = k + len;
        checks++;
        if (pe.size() != exp_pulses(len)) begin
            errors++;
            $display("FAIL hold%0d_count: got %0d want %0d", len, pe.size(), exp_pulses(len));
        end
        for (int i = 0; i < pe.size() && i < exp_pulses(len); i++) begin
            automatic int want = k + DB + 1 + ((i == 0) ? 0 : HOLD + (i - 1) * REP);
            checks++;
            if (pe[i] != want) begin
                errors++;
                $display("FAIL hold%0d_edge%0d: got k+%0d want k+%0d",
                         len, i, pe[i] - k, want - k);
            end
        end
        checks++;
        if (rise_e != k + DB + 1 || fall_e != m + DB + 1) begin
            errors++;
            $display("FAIL hold%0d_state: got rise k+%0d fall m+%0d want k+%0d m+%0d",
                     len, rise_e - k, fall_e - m, DB + 1, DB + 1);
        end
    endtask

    task automatic test_bounce();
        int   pat [6] = '{1, 3, 3, 3, 2, 3};
        int   k;
        int   hits;
        int   hit_edge;
        int   ups;
        hits     = 0;
        hit_edge = -1;
        ups      = 0;
        for (int p = 0; p < 6; p++) begin
            btn_down = (p % 2 == 0);
            repeat (pat[p]) begin
                @(negedge clk);
                if (enable !== 2'b00) hits++;
            end
        end
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL bounce_quiet: got %0d pulses want 0", hits);
        end
        k        = ecnt + 1;
        btn_down = 1'b1;
        for (int i = 0; i < 34; i++) begin
            if (i == 14) btn_down = 1'b0;
            @(negedge clk);
            if (enable === 2'b10) begin
                hits++;
                hit_edge = ecnt;
            end
            if (enable === 2'b01) ups++;
            checks++;
            if (enable !== m_en) begin
                errors++;
                $display("FAIL bounce_model: got %b want %b", enable, m_en);
            end
        end
        checks++;
        if (hits != 1 || hit_edge != k + DB + 1 || ups != 0) begin
            errors++;
            $display("FAIL bounce_press: got %0d at k+%0d (up %0d) want 1 at k+%0d",
                     hits, hit_edge - k, ups, DB + 1);
        end
    endtask

    task automatic test_simultaneous();
        int nz;
        nz       = 0;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (enable !== 2'b00) nz++;
        end
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL simul_enable: got %0d nonzero cycles want 0", nz);
        end
        checks++;
        if (btn_state !== 2'b11) begin
            errors++;
            $display("FAIL simul_state: got %b want 11", btn_state);
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (btn_state !== 2'b00 || nz != 0) begin
            errors++;
            $display("FAIL simul_release: got %b want 00", btn_state);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 9) == 0) btn_down = ~btn_down;
            if (i == 700) begin
                #2 reset = 1'b0;
                #1;
                checks++;
                if (enable !== 2'b00 || btn_state !== 2'b00) begin
                    errors++;
                    $display("FAIL random_reset: got %b/%b want 00/00", enable, btn_state);
                end
                @(negedge clk);
                reset = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (enable !== m_en || btn_state !== m_lvl) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_model: cyc %0d got %b/%b want %b/%b",
                             i, enable, btn_state, m_en, m_lvl);
            end
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        ecnt     = 0;
        reset    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        test_reset();
        test_hold(30);
        test_hold(50);
        test_hold(12);
        test_bounce();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
